// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: multi-cycle MSB-first digit-serial magnitude compare with start/busy/done handshake
module seq_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2,
  localparam int NDIG = WIDTH / DIGIT,
  localparam int CW = $clog2(NDIG + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic [CW-1:0]    scan_count
);
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;
  state_t state, state_d;
  logic [IW-1:0] idx, idx_d;
  logic [WIDTH-1:0] a_r, b_r, a_d, b_d;
  logic gt_d, lt_d, eq_d;
  logic [CW-1:0] cnt_d;
  logic [DIGIT-1:0] da, db;
  logic load;
  assign busy = state == S_SCAN;
  assign done = state == S_DONE;
  assign da = a_r[idx*DIGIT +: DIGIT];
  assign db = b_r[idx*DIGIT +: DIGIT];
  assign load = start && state != S_SCAN;
  // Signed operands are stored in offset binary so the scan itself is always unsigned
  always_comb begin
    state_d = state;
    idx_d = idx;
    a_d = a_r;
    b_d = b_r;
    gt_d = a_gt_b;
    lt_d = a_lt_b;
    eq_d = a_eq_b;
    cnt_d = scan_count;
    if (load) begin
      a_d = {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
      b_d = {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
      idx_d = IW'(NDIG - 1);
      state_d = S_SCAN;
    end else if (state == S_SCAN) begin
      if (da != db || idx == '0) begin
        gt_d = da > db;
        lt_d = da < db;
        eq_d = da == db;
        cnt_d = CW'(NDIG) - CW'(idx);
        state_d = S_DONE;
      end else begin
        idx_d = idx - IW'(1);
      end
    end else if (state == S_DONE) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx <= '0;
      a_r <= '0;
      b_r <= '0;
      a_gt_b <= 1'b0;
      a_lt_b <= 1'b0;
      a_eq_b <= 1'b0;
      scan_count <= '0;
    end else begin
      state <= state_d;
      idx <= idx_d;
      a_r <= a_d;
      b_r <= b_d;
      a_gt_b <= gt_d;
      a_lt_b <= lt_d;
      a_eq_b <= eq_d;
      scan_count <= cnt_d;
    end
  end
endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands.
- Scans the operands MSB-first, DIGIT bits per clock, and stops at the first digit that differs.
- Supports unsigned and two's-complement signed compare.
- Provides a start/busy/done handshake, so a WIDTH-wide compare fits a narrow datapath on the Elbert V2 and feeds the display/control logic.

Parameters:
- WIDTH, 8, operand width in bits; must be ≥2.
- DIGIT, 2, bits compared per clock; must divide WIDTH exactly. NDIG = WIDTH/DIGIT.
- CW, clog2(NDIG+1), width of scan_count (derived localparam, not user-set).

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request a compare; sampled only when busy=0.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while scanning.
- done  out  1  one-cycle pulse marking a valid result.
- a_gt_b  out  1  registered result, A > B.
- a_lt_b  out  1  registered result, A < B.
- a_eq_b  out  1  registered result, A = B.
- scan_count  out  CW  number of digits examined for the last result (1..NDIG).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - busy, done, a_gt_b, a_lt_b, a_eq_b = 0; scan_count = 0.
  - Internal operand registers cleared.
  - Reset mid-scan aborts the compare; no done is produced.
- States:
  - IDLE: busy=0, done=0. On start=1, latch operands and mode, set digit index = NDIG-1, go to SCAN.
  - SCAN: busy=1.
    - Each cycle, compare digit [idx*DIGIT +: DIGIT] of the latched A and B as unsigned values.
    - Digits differ: register gt/lt (eq=0), scan_count = NDIG-idx, go to DONE.
    - Digits equal and idx=0: register eq=1 (gt=lt=0), scan_count = NDIG, go to DONE.
    - Otherwise decrement idx and stay in SCAN.
  - DONE: done=1 for exactly one cycle, busy=0.
    - start=1 here is accepted: operands are latched and the next state is SCAN (back-to-back compares).
    - Otherwise go to IDLE.
- Signed mode: at latch time, invert bit WIDTH-1 of both operands (offset binary); the scan is then unsigned. No other difference.
- Latency: start is sampled at edge E0. If the decision falls on digit j (j=0 is the MSB digit), done is high after edge E(j+1). Best case is 1 cycle; equal operands take NDIG cycles.
- Result flags:
  - Change only on the edge that enters DONE.
  - Held stable until the next result.
  - After the first done, exactly one flag is high.
- Handshake:
  - start while busy=1 is ignored; no queueing.
  - a, b and signed_mode may change freely after the start cycle.
- Simultaneous rst_n=0 and start: reset wins.
- DIGIT=WIDTH degenerates to a single-cycle scan: done is high one cycle after start.

Test Plan:
- WIDTH=8, DIGIT=2, unsigned, a=0xA5, b=0x35, start 1 cycle -> busy 1 cycle; done after edge E1; a_gt_b=1, a_lt_b=0, a_eq_b=0, scan_count=1.
- Unsigned, a=0x5A, b=0x5B -> decided on LSB digit; done after E4; a_lt_b=1, scan_count=4.
- a=b=0xC3, unsigned -> done after E4; a_eq_b=1, scan_count=4.
- a=0x80, b=0x7F:
  - signed_mode=1 -> a_lt_b=1, scan_count=1.
  - Repeat with signed_mode=0 -> a_gt_b=1.
- Back-to-back and ignored start:
  - Issue compare #1 (a=0x12, b=0x13) and hold start=1 through the scan with a=0xFF, b=0x00 -> starts during SCAN are ignored.
  - Compare #1 gives lt.
  - start in the DONE cycle launches compare #2 -> gt, one cycle later.
- Mid-scan reset: start a=0x01, b=0x02, pull rst_n low after E2 -> all outputs 0 immediately, no done pulse; after release, a new compare completes normally.
